fetch_stage: RTL

- Instruction-fetch (IF) stage of the riscv32i pipeline, inside core, directly upstream of decode.
- Owns the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing everything fetched on the wrong path.

---
 rtl/core_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 63 ++++++
 rtl/fetch_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Types and constants shared by the riscv32i core pipeline stages.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } ibuf_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between instruction memory and decode.
// A flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_buffer
    import core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  ibuf_entry_t   push_entry_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output ibuf_entry_t   head_o
);

    ibuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push_i && !pop_i && !flush_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited reads to a
// 1-cycle synchronous instruction memory and hands words to decode.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;
    ibuf_entry_t   hold_q, hold_d;

    logic [CW-1:0] count;
    ibuf_entry_t   head;
    ibuf_entry_t   push_entry;
    ibuf_entry_t   view;
    logic          pop;
    logic          push;
    logic [CW:0]   used;
    logic [CW:0]   avail;

    always_comb begin
        if_valid = (count != '0);
        pop      = if_valid & id_ready & ~redirect_valid;

        // Credit > 0 is the same as count + inflight < DEPTH + pop.
        used     = {1'b0, count} + (CW+1)'(inflight_q);
        avail    = (CW+1)'(DEPTH) + (CW+1)'(pop);
        imem_req = reset & ((used < avail) | redirect_valid);

        imem_addr = redirect_valid ? word_align(redirect_pc) : pc_q;

        // The response due in a redirect cycle belongs to the wrong path.
        push            = inflight_q & ~kill_q & ~redirect_valid;
        push_entry.pc   = inflight_pc_q;
        push_entry.inst = imem_rdata;

        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imem_req;
        // Marks an outstanding request that predates a redirect; with a single
        // cycle of memory latency the target issues alongside the redirect.
        kill_d        = redirect_valid & ~imem_req;
        if (imem_req) begin
            pc_d          = imem_addr + 32'd4;
            inflight_pc_d = imem_addr;
        end

        hold_d = if_valid ? head : hold_q;
        view   = if_valid ? head : hold_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            hold_q        <= '{pc: '0, inst: NOP_INST};
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
            hold_q        <= hold_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (count),
        .head_o       (head)
    );

    assign if_pc   = view.pc;
    assign if_inst = view.inst;

endmodule
